// File: rtl/parking_gate_arbiter_pkg.sv
// Shared car-park definitions: gate state encoding, lane identifiers and default sizing.
// Also used by the password FSM and the display decoder.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_OPEN_ENTRY = 2'd1,
        ST_OPEN_EXIT  = 2'd2,
        ST_CLOSING    = 2'd3
    } gate_state_t;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_t;

    localparam int DEFAULT_CAPACITY    = 8;
    localparam int DEFAULT_OPEN_CYCLES = 4;
    localparam int DEFAULT_CNT_W       = 4;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane-controller side of the gate arbiter: requests and car sensor in, grants and status out.
interface parking_gate_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic             entry_grant;
    logic             exit_grant;
    logic             gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;

    modport master (
        output entry_req, exit_req, car_passed,
        input  entry_grant, exit_grant, gate_open, occupancy, full, empty
    );

    modport slave (
        input  entry_req, exit_req, car_passed,
        output entry_grant, exit_grant, gate_open, occupancy, full, empty
    );
endinterface

// File: rtl/parking_gate_arbiter_occupancy_counter.sv
// Saturating up/down count of cars inside the lot, with registered full/empty flags.
module occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (i_inc && !i_dec && !r_full) begin
            w_next = r_count + CNT_W'(1);
        end else if (i_dec && !i_inc && !r_empty) begin
            w_next = r_count - CNT_W'(1);
        end
    end

    // Flags are derived from the next count so they change on the same edge as the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_next;
            r_full  <= (w_next == CNT_W'(CAPACITY));
            r_empty <= (w_next == '0);
        end
    end

    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates the single barrier between entry and exit lanes, times the open window
// and counts the first car crossing in each window into the occupancy counter.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = DEFAULT_CAPACITY,
    parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    parking_gate_arbiter_if.slave bus
);

    localparam int TIMER_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    gate_state_t        r_state;
    gate_state_t        w_next_state;
    lane_t              r_last_lane;
    logic [TIMER_W-1:0] r_timer;
    logic               r_counted;
    logic               r_entry_grant;
    logic               r_exit_grant;
    logic               r_gate_open;

    logic               w_entry_elig;
    logic               w_exit_elig;
    logic               w_in_open;
    logic               w_timer_done;
    logic               w_grant_entry;
    logic               w_grant_exit;
    logic               w_inc;
    logic               w_dec;
    logic [CNT_W-1:0]   w_occupancy;
    logic               w_full;
    logic               w_empty;

    assign w_entry_elig = bus.entry_req && !w_full;
    assign w_exit_elig  = bus.exit_req && !w_empty;
    assign w_in_open    = (r_state == ST_OPEN_ENTRY) || (r_state == ST_OPEN_EXIT);
    assign w_timer_done = (r_timer == TIMER_W'(OPEN_CYCLES - 1));

    // On a tie the lane not served last wins; held-off requests simply stay ineligible.
    always_comb begin
        w_next_state  = r_state;
        w_grant_entry = 1'b0;
        w_grant_exit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_entry_elig && (!w_exit_elig || r_last_lane == LANE_EXIT)) begin
                    w_next_state  = ST_OPEN_ENTRY;
                    w_grant_entry = 1'b1;
                end else if (w_exit_elig) begin
                    w_next_state = ST_OPEN_EXIT;
                    w_grant_exit = 1'b1;
                end
            end
            ST_OPEN_ENTRY, ST_OPEN_EXIT: begin
                if (w_timer_done) begin
                    w_next_state = ST_CLOSING;
                end
            end
            ST_CLOSING: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_last_lane   <= LANE_EXIT;
            r_counted     <= 1'b0;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_gate_open   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_entry_grant <= w_grant_entry;
            r_exit_grant  <= w_grant_exit;
            r_gate_open   <= (w_next_state == ST_OPEN_ENTRY) || (w_next_state == ST_OPEN_EXIT);

            if (w_in_open && !w_timer_done) begin
                r_timer <= r_timer + TIMER_W'(1);
            end else begin
                r_timer <= '0;
            end

            if (r_state == ST_IDLE) begin
                r_counted <= 1'b0;
            end else if (w_in_open && bus.car_passed) begin
                r_counted <= 1'b1;
            end

            if (w_grant_entry) begin
                r_last_lane <= LANE_ENTRY;
            end else if (w_grant_exit) begin
                r_last_lane <= LANE_EXIT;
            end
        end
    end

    // Only the first crossing of a window moves the count.
    assign w_inc = (r_state == ST_OPEN_ENTRY) && bus.car_passed && !r_counted;
    assign w_dec = (r_state == ST_OPEN_EXIT) && bus.car_passed && !r_counted;

    occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (w_occupancy),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.entry_grant = r_entry_grant;
    assign bus.exit_grant  = r_exit_grant;
    assign bus.gate_open   = r_gate_open;
    assign bus.occupancy   = w_occupancy;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_parking_gate_arbiter;

    localparam int CAP  = 8;
    localparam int OPEN = 4;
    localparam int CW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp  = 0;
    int   nerr  = 0;

    parking_gate_arbiter_if #(.CNT_W(CW)) bus ();

    parking_gate_arbiter #(
        .CAPACITY    (CAP),
        .OPEN_CYCLES (OPEN),
        .CNT_W       (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One full request/grant/window sequence, leaving the arbiter back in IDLE.
    task automatic do_pass(input bit isEntry, input bit withCar);
        int   waited;
        logic g;
        waited = 0;
        g      = 1'b0;
        if (isEntry) bus.entry_req = 1'b1;
        else         bus.exit_req  = 1'b1;
        while (!g && waited < 20) begin
            @(negedge clk);
            waited++;
            g = isEntry ? bus.entry_grant : bus.exit_grant;
        end
        if (!g) begin
            ncmp++;
            nerr++;
            $display("[TB] FAIL pass_grant_timeout: got no grant in %0d cycles, required a grant", waited);
        end
        if (isEntry) bus.entry_req = 1'b0;
        else         bus.exit_req  = 1'b0;
        bus.car_passed = withCar;
        @(negedge clk);
        bus.car_passed = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.car_passed = 1'b0;
        repeat (3) @(negedge clk);
        ncmp++; if (bus.entry_grant !== 1'b0) begin nerr++; $display("[TB] FAIL reset_entry_grant: got %b required 0", bus.entry_grant); end
        ncmp++; if (bus.exit_grant !== 1'b0) begin nerr++; $display("[TB] FAIL reset_exit_grant: got %b required 0", bus.exit_grant); end
        ncmp++; if (bus.gate_open !== 1'b0) begin nerr++; $display("[TB] FAIL reset_gate_open: got %b required 0", bus.gate_open); end
        ncmp++; if (bus.occupancy !== 4'd0) begin nerr++; $display("[TB] FAIL reset_occupancy: got %0d required 0", bus.occupancy); end
        ncmp++; if (bus.full !== 1'b0) begin nerr++; $display("[TB] FAIL reset_full: got %b required 0", bus.full); end
        ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("[TB] FAIL reset_empty: got %b required 1", bus.empty); end
        rst_n = 1'b1;
        @(negedge clk);
        ncmp++; if (bus.gate_open !== 1'b0) begin nerr++; $display("[TB] FAIL idle_gate_open: got %b required 0", bus.gate_open); end
    endtask

    task automatic test_entry_basic;
        int gateCnt;
        int grantCnt;
        gateCnt  = 0;
        grantCnt = 0;
        bus.entry_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.gate_open === 1'b1) gateCnt++;
            if (bus.entry_grant === 1'b1) grantCnt++;
            if (i == 1) begin
                ncmp++; if (bus.entry_grant !== 1'b1) begin nerr++; $display("[TB] FAIL entry_grant_first_cycle: got %b required 1", bus.entry_grant); end
                ncmp++; if (bus.gate_open !== 1'b1) begin nerr++; $display("[TB] FAIL entry_gate_first_cycle: got %b required 1", bus.gate_open); end
                bus.entry_req = 1'b0;
            end
            if (i == 2) begin
                ncmp++; if (bus.occupancy !== 4'd0) begin nerr++; $display("[TB] FAIL entry_occ_before_car: got %0d required 0", bus.occupancy); end
            end
            if (i == 3) begin
                ncmp++; if (bus.occupancy !== 4'd1) begin nerr++; $display("[TB] FAIL entry_occ_after_car: got %0d required 1", bus.occupancy); end
                ncmp++; if (bus.empty !== 1'b0) begin nerr++; $display("[TB] FAIL entry_empty_after_car: got %b required 0", bus.empty); end
            end
            bus.car_passed = (i == 2);
        end
        bus.car_passed = 1'b0;
        ncmp++; if (gateCnt != OPEN) begin nerr++; $display("[TB] FAIL entry_gate_cycles: got %0d required %0d", gateCnt, OPEN); end
        ncmp++; if (grantCnt != 1) begin nerr++; $display("[TB] FAIL entry_grant_pulses: got %0d required 1", grantCnt); end
    endtask

    task automatic test_tie;
        int entryIdx;
        int exitIdx;
        entryIdx = -1;
        exitIdx  = -1;
        do_pass(1'b1, 1'b1);
        do_pass(1'b1, 1'b1);
        do_pass(1'b1, 1'b1);
        do_pass(1'b0, 1'b1);
        ncmp++; if (bus.occupancy !== 4'd3) begin nerr++; $display("[TB] FAIL tie_setup_occ: got %0d required 3", bus.occupancy); end
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (bus.entry_grant === 1'b1 && entryIdx < 0) begin entryIdx = i; bus.entry_req = 1'b0; end
            if (bus.exit_grant === 1'b1 && exitIdx < 0) begin exitIdx = i; bus.exit_req = 1'b0; end
            if (i == 3) begin
                ncmp++; if (bus.occupancy !== 4'd4) begin nerr++; $display("[TB] FAIL tie_occ_after_entry: got %0d required 4", bus.occupancy); end
            end
            bus.car_passed = (i == 2) || (i == 8);
        end
        bus.car_passed = 1'b0;
        ncmp++; if (entryIdx != 1) begin nerr++; $display("[TB] FAIL tie_entry_first: got cycle %0d required 1", entryIdx); end
        ncmp++; if (exitIdx != 1 + OPEN + 2) begin nerr++; $display("[TB] FAIL tie_exit_spacing: got cycle %0d required %0d", exitIdx, 1 + OPEN + 2); end
        ncmp++; if (bus.occupancy !== 4'd3) begin nerr++; $display("[TB] FAIL tie_occ_final: got %0d required 3", bus.occupancy); end
    endtask

    task automatic test_multi_pulse;
        bus.entry_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                ncmp++; if (bus.entry_grant !== 1'b1) begin nerr++; $display("[TB] FAIL multi_grant: got %b required 1", bus.entry_grant); end
                bus.entry_req = 1'b0;
            end
            if (i == 2) begin
                ncmp++; if (bus.occupancy !== 4'd4) begin nerr++; $display("[TB] FAIL multi_first_pulse: got %0d required 4", bus.occupancy); end
            end
            bus.car_passed = (i == 1) || (i == 3) || (i == 4) || (i == 5) || (i == 6);
        end
        bus.car_passed = 1'b0;
        ncmp++; if (bus.occupancy !== 4'd4) begin nerr++; $display("[TB] FAIL multi_pulse_once: got %0d required 4", bus.occupancy); end
        do_pass(1'b1, 1'b0);
        ncmp++; if (bus.occupancy !== 4'd4) begin nerr++; $display("[TB] FAIL aborted_pass: got %0d required 4", bus.occupancy); end
    endtask

    task automatic test_full;
        int gateCnt;
        int grantCnt;
        int entryIdx;
        int exitIdx;
        gateCnt  = 0;
        grantCnt = 0;
        entryIdx = -1;
        exitIdx  = -1;
        for (int k = 0; k < 4; k++) do_pass(1'b1, 1'b1);
        ncmp++; if (bus.occupancy !== 4'd8) begin nerr++; $display("[TB] FAIL full_occ: got %0d required 8", bus.occupancy); end
        ncmp++; if (bus.full !== 1'b1) begin nerr++; $display("[TB] FAIL full_flag: got %b required 1", bus.full); end
        bus.entry_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.gate_open === 1'b1) gateCnt++;
            if (bus.entry_grant === 1'b1) grantCnt++;
        end
        ncmp++; if (grantCnt != 0) begin nerr++; $display("[TB] FAIL full_entry_held: got %0d grants required 0", grantCnt); end
        ncmp++; if (gateCnt != 0) begin nerr++; $display("[TB] FAIL full_gate_closed: got %0d open cycles required 0", gateCnt); end
        bus.exit_req = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (bus.exit_grant === 1'b1 && exitIdx < 0) begin exitIdx = i; bus.exit_req = 1'b0; end
            if (bus.entry_grant === 1'b1 && entryIdx < 0) begin entryIdx = i; bus.entry_req = 1'b0; end
            if (i == 2) begin
                ncmp++; if (bus.occupancy !== 4'd7) begin nerr++; $display("[TB] FAIL full_exit_occ: got %0d required 7", bus.occupancy); end
                ncmp++; if (bus.full !== 1'b0) begin nerr++; $display("[TB] FAIL full_flag_clear: got %b required 0", bus.full); end
            end
            bus.car_passed = (i == 1);
        end
        bus.car_passed = 1'b0;
        bus.entry_req  = 1'b0;
        ncmp++; if (exitIdx != 1) begin nerr++; $display("[TB] FAIL full_exit_grant: got cycle %0d required 1", exitIdx); end
        ncmp++; if (entryIdx != 1 + OPEN + 2) begin nerr++; $display("[TB] FAIL full_held_entry: got cycle %0d required %0d", entryIdx, 1 + OPEN + 2); end
        ncmp++; if (bus.occupancy !== 4'd7) begin nerr++; $display("[TB] FAIL full_final_occ: got %0d required 7", bus.occupancy); end
    endtask

    task automatic test_reset_mid_window;
        bus.exit_req = 1'b1;
        @(negedge clk);
        ncmp++; if (bus.exit_grant !== 1'b1) begin nerr++; $display("[TB] FAIL midrst_exit_grant: got %b required 1", bus.exit_grant); end
        bus.exit_req  = 1'b0;
        bus.entry_req = 1'b1;
        @(negedge clk);
        ncmp++; if (bus.gate_open !== 1'b1) begin nerr++; $display("[TB] FAIL midrst_gate_before: got %b required 1", bus.gate_open); end
        #2 rst_n = 1'b0;
        #1;
        ncmp++; if (bus.gate_open !== 1'b0) begin nerr++; $display("[TB] FAIL midrst_gate_async: got %b required 0", bus.gate_open); end
        ncmp++; if (bus.occupancy !== 4'd0) begin nerr++; $display("[TB] FAIL midrst_occ: got %0d required 0", bus.occupancy); end
        ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("[TB] FAIL midrst_empty: got %b required 1", bus.empty); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ncmp++; if (bus.entry_grant !== 1'b0) begin nerr++; $display("[TB] FAIL midrst_no_grant: got %b required 0", bus.entry_grant); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        ncmp++; if (bus.entry_grant !== 1'b1) begin nerr++; $display("[TB] FAIL midrst_grant_after: got %b required 1", bus.entry_grant); end
        ncmp++; if (bus.gate_open !== 1'b1) begin nerr++; $display("[TB] FAIL midrst_gate_after: got %b required 1", bus.gate_open); end
        bus.entry_req = 1'b0;
        repeat (5) @(negedge clk);
        ncmp++; if (bus.occupancy !== 4'd0) begin nerr++; $display("[TB] FAIL midrst_occ_final: got %0d required 0", bus.occupancy); end
    endtask

    task automatic test_empty_exit;
        int gateCnt;
        int grantCnt;
        gateCnt  = 0;
        grantCnt = 0;
        bus.exit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.gate_open === 1'b1) gateCnt++;
            if (bus.exit_grant === 1'b1) grantCnt++;
        end
        bus.exit_req = 1'b0;
        ncmp++; if (grantCnt != 0) begin nerr++; $display("[TB] FAIL empty_exit_held: got %0d grants required 0", grantCnt); end
        ncmp++; if (gateCnt != 0) begin nerr++; $display("[TB] FAIL empty_gate_closed: got %0d open cycles required 0", gateCnt); end
        ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("[TB] FAIL empty_flag: got %b required 1", bus.empty); end
    endtask

    initial begin
        test_reset();
        test_entry_basic();
        test_tie();
        test_multi_pulse();
        test_full();
        test_reset_mid_window();
        test_empty_exit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single barrier gate of the car park between the entry lane and the exit lane. Entry requests come from the password FSM once a password is accepted; exit requests come from the exit sensor logic. The block arbitrates the two requesters, times the gate-open window and tracks lot occupancy against a fixed capacity. It sits between the lane controllers and the barrier motor / LED / 7-segment drivers.

## Interface
- CAPACITY, 8: number of parking slots (1..15).
- OPEN_CYCLES, 4: clock cycles the gate stays open per grant (≥2).
- CNT_W, 4: occupancy counter width; must hold CAPACITY.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_req  in  1  level; entry car authorised, held until entry_grant.
- exit_req  in  1  level; car waiting at exit, held until exit_grant.
- car_passed  in  1  one-cycle pulse from the gate sensor; a car crossed.
- entry_grant  out  1  one-cycle pulse; entry request accepted.
- exit_grant  out  1  one-cycle pulse; exit request accepted.
- gate_open  out  1  barrier motor command, high while open.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.

## Operation
- States: IDLE, OPEN_ENTRY, OPEN_EXIT, CLOSING.
- IDLE: entry eligible if entry_req && !full; exit eligible if exit_req && !empty.
- One eligible -> go to its OPEN state. Both eligible -> serve the lane not served last (last_lane flag, reset = exit, so entry wins the first tie). None -> stay.
- Ineligible requests (entry while full, exit while empty) are held off, not dropped; they are served once eligible.
- OPEN_x: timer counts 0..OPEN_CYCLES-1; at last count -> CLOSING.
- First car_passed in an OPEN state updates occupancy at that edge: +1 in OPEN_ENTRY, -1 in OPEN_EXIT. Further pulses in the same window are ignored. No pulse -> occupancy unchanged (aborted pass).
- car_passed in IDLE or CLOSING is ignored.
- CLOSING: one cycle, gate_open low, then IDLE; requests seen in CLOSING wait until IDLE.
- Occupancy never wraps: increments are impossible when full, decrements impossible when empty, by eligibility.

## Timing
- Reset: state IDLE, timer 0, occupancy 0, last_lane = exit; entry_grant 0, exit_grant 0, gate_open 0, full 0, empty 1.
- Reset mid-window closes the gate immediately (asynchronously) and clears occupancy.
- All outputs registered. A request sampled high in IDLE at edge N -> grant pulse and gate_open high from edge N (visible after edge N) for exactly OPEN_CYCLES cycles.
- Grant pulse is exactly one cycle, coincident with the first open cycle.
- Minimum spacing between grants: OPEN_CYCLES + 2 cycles (open window, CLOSING, IDLE sample).
- occupancy/full/empty update on the edge that samples the counted car_passed.

## Structure
- Shared package parking_pkg: gate state encoding (2-bit), lane enum (ENTRY/EXIT), default CAPACITY and OPEN_CYCLES constants, shared with the password FSM and display decoder.
- One sub-module natural: occupancy_counter (up/down, saturating, full/empty flags, CNT_W and CAPACITY parameters).
- Arbiter FSM, timer and last_lane flag live in the top.

## Test plan
- Reset then entry_req=1 at cycle 2 with car_passed at the second open cycle -> entry_grant pulse, gate_open high 4 cycles, occupancy 0->1, empty 1->0.
- entry_req and exit_req both high from IDLE with occupancy=3 -> entry granted first, exit granted OPEN_CYCLES+2 cycles later; occupancy 3->4->3.
- Fill to 8 then entry_req held -> no entry_grant, full=1; exit_req + car_passed -> occupancy 7, held entry then granted.
- exit_req with occupancy 0 -> no grant, gate_open stays 0.
- Three car_passed pulses in one entry window -> occupancy +1 only; no car_passed -> occupancy unchanged.
- reset asserted in the second cycle of OPEN_EXIT -> gate_open 0 immediately, occupancy 0, state IDLE, no grant until reset released.
